// File: rtl/delay_pkg.sv
// delay_pkg: shared state/fault encodings and timing thresholds for the tick monitor
//   early_thr(n, tol) -> smallest on-time gap
//   late_thr(n, tol)  -> largest on-time gap; a missing pulse here is late
package delay_pkg;
    typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED, FAULT} state_t;
    typedef enum logic [1:0] {FC_NONE, FC_EARLY, FC_LATE, FC_UPSTREAM} fcode_t;
    function automatic int early_thr(int n, int tol);
        return n - tol;
    endfunction
    function automatic int late_thr(int n, int tol);
        return n + tol;
    endfunction
endpackage

// File: rtl/gap_timer.sv
// gap_timer: saturating count of non-pulse cycles with spacing classification
//   clk, rst    clock, sync active-high reset
//   restart     clears the gap (acquisition restart)
//   sig         tick pulse
//   early       pulse with gap below the window
//   on_time     pulse with gap inside the window
//   late        no pulse while gap sits at the window's upper edge
module gap_timer
    import delay_pkg::*;
#(
    parameter int N     = 100000,
    parameter int CBITS = 17,
    parameter int TOL   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic sig,
    output logic early,
    output logic on_time,
    output logic late
);
    localparam int W = CBITS + 1;
    localparam logic [W-1:0] LO = W'(early_thr(N, TOL));
    localparam logic [W-1:0] HI = W'(late_thr(N, TOL));

    logic [W-1:0] gap;

    always_ff @(posedge clk) begin
        if (rst || restart || sig) gap <= '0;
        else if (gap != '1) gap <= gap + W'(1);
    end

    assign early   = sig && (gap < LO);
    assign on_time = sig && (gap >= LO) && (gap <= HI);
    assign late    = !sig && (gap == HI);
endmodule

// File: rtl/delay_tick_monitor.sv
// delay_tick_monitor: qualifies the generator tick stream, locks, and latches faults
//   clk, rst    clock, sync active-high reset
//   sig_in      tick pulse, err_in overrun flag, flg_in in-range flag
//   clr         clears a sticky fault and restarts acquisition
//   tick_stb    one-cycle strobe per accepted tick; tick_cnt wrapping count
//   locked      LOCKED state; fault / fault_code sticky fault and its first cause
module delay_tick_monitor
    import delay_pkg::*;
#(
    parameter int N        = 100000,
    parameter int CBITS    = 17,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4,
    parameter int EV_BITS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               err_in,
    input  logic               flg_in,
    input  logic               clr,
    output logic               tick_stb,
    output logic [EV_BITS-1:0] tick_cnt,
    output logic               locked,
    output logic               fault,
    output logic [1:0]         fault_code
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK = GW'(LOCK_CNT);

    state_t        state, state_n;
    fcode_t        code, code_n;
    logic [GW-1:0] good, good_n;
    logic          accept;
    logic          early, on_time, late;

    gap_timer #(.N(N), .CBITS(CBITS), .TOL(TOL)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .restart(clr),
        .sig    (sig_in),
        .early  (early),
        .on_time(on_time),
        .late   (late)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQUIRE;
            code     <= FC_NONE;
            good     <= '0;
            tick_stb <= 1'b0;
            tick_cnt <= '0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            good     <= good_n;
            tick_stb <= accept;
            tick_cnt <= tick_cnt + EV_BITS'(accept);
        end
    end

    // Fault causes are tested in priority order: upstream, early, late.
    always_comb begin
        state_n = state;
        code_n  = code;
        good_n  = good;
        accept  = 1'b0;
        if (clr) begin
            state_n = ACQUIRE;
            code_n  = FC_NONE;
            good_n  = '0;
        end else if (state != FAULT) begin
            if (err_in || !flg_in) begin
                state_n = FAULT;
                code_n  = FC_UPSTREAM;
            end else if (state == ACQUIRE) begin
                if (late) begin
                    state_n = FAULT;
                    code_n  = FC_LATE;
                end else if (sig_in) begin
                    accept  = 1'b1;
                    good_n  = GW'(1);
                    state_n = (LOCK_CNT == 1) ? LOCKED : TRACK;
                end
            end else if (early) begin
                state_n = FAULT;
                code_n  = FC_EARLY;
            end else if (late) begin
                state_n = FAULT;
                code_n  = FC_LATE;
            end else if (on_time) begin
                accept  = 1'b1;
                good_n  = (good >= LOCK) ? good : good + GW'(1);
                state_n = (good_n >= LOCK) ? LOCKED : state;
            end
        end
    end

    assign locked     = (state == LOCKED);
    assign fault      = (state == FAULT);
    assign fault_code = code;
endmodule
